cpu_status: RTL and testbench

CPU_STATUS -- requirements
Module: cpu_status

---
 rtl/cpu_status_if.sv | 45 ++++
 rtl/cpu_status.sv | 147 ++++++++++++++
 tb/tb_cpu_status.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_status_if.sv
// -----------------------------------------------------------------------------
// cpu_status_if
//   Signal bundle between the debug/monitor side and the cpu_status sequencer.
//
//   Control (driven by the master, sampled by cpu_status):
//     cpu_start  one-cycle start pulse
//     quit_cmd   one-cycle stop request
//     stall      memory-wait hold, honoured in IF and MA only
//     step_mode  level, halt after each instruction (STEP_MODE_EN builds)
//     step_go    one-cycle pulse releasing one instruction (STEP_MODE_EN builds)
//   Status (driven by cpu_status):
//     cpu_stat_pc .. cpu_stat_wb  one-hot stage strobes
//     cpu_run    sequencer not idle
//     cpu_hold   sequencer parked in STEP
//     instr_ret  32-bit retired-instruction count
// -----------------------------------------------------------------------------
interface cpu_status_if;
  logic        cpu_start;
  logic        quit_cmd;
  logic        stall;
  logic        step_mode;
  logic        step_go;

  logic        cpu_stat_pc;
  logic        cpu_stat_if;
  logic        cpu_stat_id;
  logic        cpu_stat_ex;
  logic        cpu_stat_ma;
  logic        cpu_stat_wb;
  logic        cpu_run;
  logic        cpu_hold;
  logic [31:0] instr_ret;

  modport master (
    output cpu_start, quit_cmd, stall, step_mode, step_go,
    input  cpu_stat_pc, cpu_stat_if, cpu_stat_id, cpu_stat_ex,
           cpu_stat_ma, cpu_stat_wb, cpu_run, cpu_hold, instr_ret
  );

  modport slave (
    input  cpu_start, quit_cmd, stall, step_mode, step_go,
    output cpu_stat_pc, cpu_stat_if, cpu_stat_id, cpu_stat_ex,
           cpu_stat_ma, cpu_stat_wb, cpu_run, cpu_hold, instr_ret
  );
endinterface

// File: rtl/cpu_status.sv
// -----------------------------------------------------------------------------
// cpu_status
//   Instruction-stage sequencer for a simple multi-cycle CPU. Walks
//   PC -> IF -> ID -> EX -> MA -> WB once per instruction, holds IF/MA while
//   stall is high, counts retired instructions and stops cleanly on quit.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous, active-low reset
//     bus    cpu_status_if.slave (control inputs, stage strobes, counter)
//
//   Build option:
//     STEP_MODE_EN  when defined, adds the STEP state: with step_mode=1 the
//                   sequencer parks after every WB until step_go (or quit).
//                   When undefined, step_mode/step_go are ignored and
//                   cpu_hold is tied low.
// -----------------------------------------------------------------------------
module cpu_status (
  input  logic         clk,
  input  logic         rst_n,
  cpu_status_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PC,
    S_IF,
    S_ID,
    S_EX,
    S_MA,
    S_WB
`ifdef STEP_MODE_EN
    , S_STEP
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        quit_pend_q;
  logic        quit_pend_d;
  logic [31:0] instr_ret_q;
  logic [31:0] instr_ret_d;
  logic        quit_seen;

  // A quit arriving in the WB cycle itself counts as pending, so the
  // instruction in flight still retires but no new one is fetched.
  assign quit_seen = quit_pend_q | bus.quit_cmd;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.cpu_start) state_d = S_PC;
      S_PC:   state_d = S_IF;
      S_IF:   if (!bus.stall) state_d = S_ID;
      S_ID:   state_d = S_EX;
      S_EX:   state_d = S_MA;
      S_MA:   if (!bus.stall) state_d = S_WB;
      S_WB: begin
        if (quit_seen)          state_d = S_IDLE;
`ifdef STEP_MODE_EN
        else if (bus.step_mode) state_d = S_STEP;
`endif
        else                    state_d = S_PC;
      end
`ifdef STEP_MODE_EN
      S_STEP: begin
        // quit beats step_go when both arrive together
        if (bus.quit_cmd)     state_d = S_IDLE;
        else if (bus.step_go) state_d = S_PC;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Quit is remembered until the sequencer actually reaches IDLE; a quit
  // seen while already idle has nothing to stop and is dropped.
  always_comb begin
    quit_pend_d = quit_pend_q;
    if (state_d == S_IDLE)
      quit_pend_d = 1'b0;
    else if (state_q != S_IDLE && bus.quit_cmd)
      quit_pend_d = 1'b1;
  end

  // Counter restarts only on an accepted start; it is left untouched in
  // IDLE so the final count can be read out after a quit.
  assign instr_ret_d = (state_q == S_IDLE && bus.cpu_start) ? 32'd0
                     : (state_q == S_WB)                    ? instr_ret_q + 32'd1
                     :                                        instr_ret_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      quit_pend_q <= 1'b0;
      instr_ret_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      quit_pend_q <= quit_pend_d;
      instr_ret_q <= instr_ret_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, purely from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cpu_stat_pc = 1'b0;
    bus.cpu_stat_if = 1'b0;
    bus.cpu_stat_id = 1'b0;
    bus.cpu_stat_ex = 1'b0;
    bus.cpu_stat_ma = 1'b0;
    bus.cpu_stat_wb = 1'b0;
    unique case (state_q)
      S_PC:    bus.cpu_stat_pc = 1'b1;
      S_IF:    bus.cpu_stat_if = 1'b1;
      S_ID:    bus.cpu_stat_id = 1'b1;
      S_EX:    bus.cpu_stat_ex = 1'b1;
      S_MA:    bus.cpu_stat_ma = 1'b1;
      S_WB:    bus.cpu_stat_wb = 1'b1;
      default: ;
    endcase
  end

  assign bus.cpu_run   = (state_q != S_IDLE);
  assign bus.instr_ret = instr_ret_q;

`ifdef STEP_MODE_EN
  assign bus.cpu_hold = (state_q == S_STEP);
`else
  assign bus.cpu_hold = 1'b0;
  // step controls have no effect in this build
  logic unused_step;
  assign unused_step = bus.step_mode ^ bus.step_go;
`endif

endmodule

// File: tb/tb_cpu_status.sv
// -----------------------------------------------------------------------------
// tb_cpu_status
//   Self-checking bench for cpu_status. A behavioural reference tracks the
//   current stage as a position in the PC..WB sequence plus a pending-quit
//   flag and a retired count; directed scenarios are followed by random
//   stimulus. Works in both default and STEP_MODE_EN builds.
// -----------------------------------------------------------------------------
module tb_cpu_status;

`ifdef STEP_MODE_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // reference positions: 0..5 = PC,IF,ID,EX,MA,WB
  localparam int P_IDLE = -1;
  localparam int P_STEP = 6;

  logic clk = 1'b0;
  logic rst_n;

  cpu_status_if bus ();

  cpu_status dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_pos  = P_IDLE;
  bit          m_quit = 1'b0;
  logic [31:0] m_cnt  = 32'd0;

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    int nxt;
    bit quit_now;
    if (!rst_n) begin
      m_pos  = P_IDLE;
      m_quit = 1'b0;
      m_cnt  = 32'd0;
      return;
    end
    nxt      = m_pos;
    quit_now = m_quit || bus.quit_cmd;
    if (m_pos == P_IDLE) begin
      if (bus.cpu_start) begin
        nxt   = 0;
        m_cnt = 32'd0;
      end
    end else if (m_pos == P_STEP) begin
      if (bus.quit_cmd)     nxt = P_IDLE;
      else if (bus.step_go) nxt = 0;
    end else if (m_pos == 5) begin
      m_cnt = m_cnt + 32'd1;
      if (quit_now)                    nxt = P_IDLE;
      else if (STEP_EN && bus.step_mode) nxt = P_STEP;
      else                             nxt = 0;
    end else if ((m_pos == 1 || m_pos == 4) && bus.stall) begin
      nxt = m_pos;
    end else begin
      nxt = m_pos + 1;
    end
    if (nxt == P_IDLE)                         m_quit = 1'b0;
    else if (m_pos != P_IDLE && bus.quit_cmd)  m_quit = 1'b1;
    m_pos = nxt;
  endtask

  function automatic logic [5:0] stat_vec();
    return {bus.cpu_stat_wb, bus.cpu_stat_ma, bus.cpu_stat_ex,
            bus.cpu_stat_id, bus.cpu_stat_if, bus.cpu_stat_pc};
  endfunction

  task automatic compare();
    logic [5:0] exp_stat;
    exp_stat = (m_pos >= 0 && m_pos <= 5) ? 6'(1 << m_pos) : 6'd0;
    check("stage_strobes", 32'(stat_vec()), 32'(exp_stat));
    check("cpu_run",       32'(bus.cpu_run),  32'(m_pos != P_IDLE));
    check("cpu_hold",      32'(bus.cpu_hold), 32'(m_pos == P_STEP));
    check("instr_ret",     bus.instr_ret,     m_cnt);
  endtask

  // One clock: predict, clock, then compare 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run_until(input int pos, input int budget);
    int n = 0;
    while (m_pos != pos && n < budget) begin
      tick();
      n++;
    end
    check("reach_stage", 32'(m_pos), 32'(pos));
  endtask

  task automatic start();
    bus.cpu_start = 1'b1;
    tick();
    bus.cpu_start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] saved;
    int          ma_cycles;

    rst_n         = 1'b0;
    bus.cpu_start = 1'b0;
    bus.quit_cmd  = 1'b0;
    bus.stall     = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_go   = 1'b0;

    // outputs during reset
    #2;
    check("rst_stat", 32'(stat_vec()), 32'd0);
    check("rst_run",  32'(bus.cpu_run), 32'd0);
    check("rst_hold", 32'(bus.cpu_hold), 32'd0);
    check("rst_cnt",  bus.instr_ret, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // stays idle without a start; start pulse drives the fixed timeline
    repeat (3) tick();
    start();
    check("start_pc", 32'(bus.cpu_stat_pc), 32'd1);
    repeat (5) tick();
    check("wb_after_5", 32'(bus.cpu_stat_wb), 32'd1);
    tick();
    check("pc_after_6", 32'(bus.cpu_stat_pc), 32'd1);
    check("cnt_after_1", bus.instr_ret, 32'd1);

    // three stall cycles in MA
    run_until(4, 20);
    saved     = bus.instr_ret;
    ma_cycles = 1;
    bus.stall = 1'b1;
    repeat (3) begin
      tick();
      ma_cycles += int'(bus.cpu_stat_ma);
    end
    bus.stall = 1'b0;
    tick();
    check("ma_cycles", 32'(ma_cycles), 32'd4);
    check("wb_after_stall", 32'(bus.cpu_stat_wb), 32'd1);
    tick();
    check("cnt_after_stall", bus.instr_ret, saved + 32'd1);

    // start while running is ignored
    run_until(2, 20);
    bus.cpu_start = 1'b1;
    tick();
    bus.cpu_start = 1'b0;

    // quit during EX: MA, WB complete then idle
    run_until(3, 20);
    bus.quit_cmd = 1'b1;
    tick();
    bus.quit_cmd = 1'b0;
    check("quit_ma", 32'(bus.cpu_stat_ma), 32'd1);
    tick();
    check("quit_wb", 32'(bus.cpu_stat_wb), 32'd1);
    tick();
    check("quit_idle_run", 32'(bus.cpu_run), 32'd0);
    saved = bus.instr_ret;
    repeat (3) tick();
    check("cnt_frozen", bus.instr_ret, saved);

    // quit in idle is dropped: next instruction runs past WB
    bus.quit_cmd = 1'b1;
    tick();
    bus.quit_cmd = 1'b0;
    start();
    run_until(5, 20);
    tick();
    check("idle_quit_ignored", 32'(bus.cpu_stat_pc), 32'd1);

    // step mode
    bus.step_mode = 1'b1;
`ifdef STEP_MODE_EN
    run_until(P_STEP, 20);
    check("step_hold", 32'(bus.cpu_hold), 32'd1);
    repeat (3) tick();
    bus.step_go = 1'b1;
    tick();
    bus.step_go = 1'b0;
    check("step_go_pc", 32'(bus.cpu_stat_pc), 32'd1);
    run_until(P_STEP, 20);
    bus.step_go  = 1'b1;
    bus.quit_cmd = 1'b1;
    tick();
    bus.step_go  = 1'b0;
    bus.quit_cmd = 1'b0;
    check("step_quit_idle", 32'(bus.cpu_run), 32'd0);
    bus.step_mode = 1'b0;
`else
    run_until(5, 20);
    tick();
    check("no_step_pc", 32'(bus.cpu_stat_pc), 32'd1);
    check("no_step_hold", 32'(bus.cpu_hold), 32'd0);
    bus.step_mode = 1'b0;
    bus.quit_cmd  = 1'b1;
    tick();
    bus.quit_cmd  = 1'b0;
    run_until(P_IDLE, 20);
`endif

    // counter wrap from a preloaded all-ones value
    start();
    force dut.instr_ret_d = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.instr_ret_d;
    check("preload", bus.instr_ret, 32'hFFFF_FFFF);
    run_until(0, 20);
    check("wrap", bus.instr_ret, 32'd0);

    // asynchronous reset while in ID
    run_until(2, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stat", 32'(stat_vec()), 32'd0);
    check("arst_run",  32'(bus.cpu_run), 32'd0);
    check("arst_hold", 32'(bus.cpu_hold), 32'd0);
    check("arst_cnt",  bus.instr_ret, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.cpu_start = ($urandom_range(0, 15) == 0);
      bus.quit_cmd  = ($urandom_range(0, 39) == 0);
      bus.stall     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) bus.step_mode = ~bus.step_mode;
      bus.step_go   = ($urandom_range(0, 3) == 0);
      rst_n         = ($urandom_range(0, 499) != 0);
      tick();
    end

    bus.cpu_start = 1'b0;
    bus.quit_cmd  = 1'b0;
    bus.stall     = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_go   = 1'b0;
    rst_n         = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
